// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// controller state and the register-zero constant.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXE   = 2'b01;
  localparam logic [1:0] FWD_MEM   = 2'b10;
  localparam logic [1:0] FWD_MEMLD = 2'b11;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MEMWAIT = 1'b1
  } state_e;

  localparam logic [4:0] R0 = 5'd0;

  // Wide enough for any WAIT_MAX in 1..255.
  localparam int WCNT_W = 8;

endpackage

// File: rtl/pipe_fwd_sel.sv
// Forwarding compare for one ID source operand; EXE ALU results win over MEM,
// and register zero is never forwarded.
module pipe_fwd_sel
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] ern,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] mrn,
  input  logic       mwreg,
  input  logic       mm2reg,
  output logic [1:0] fwd
);

  always_comb begin
    // NOTE: default first so every path assigns fwd and no latch is inferred.
    fwd = FWD_RF;
    if (ewreg && !em2reg && (ern != R0) && (ern == src)) begin
      fwd = FWD_EXE;
    end else if (mwreg && !mm2reg && (mrn != R0) && (mrn == src)) begin
      fwd = FWD_MEM;
    end else if (mwreg && mm2reg && (mrn != R0) && (mrn == src)) begin
      fwd = FWD_MEMLD;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller: operand forwarding, load-use interlock,
// branch flush and a MEM-stage freeze with timeout while memory/IO is pending.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             br_taken,
  input  logic [4:0]       ern,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       mrn,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             wpcir,
  output logic             de_en,
  output logic             de_bubble,
  output logic             if_flush,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              bus_err_q, bus_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              lu;

  pipe_fwd_sel u_fwd_a (
    .src    (rs),
    .ern    (ern),
    .ewreg  (ewreg),
    .em2reg (em2reg),
    .mrn    (mrn),
    .mwreg  (mwreg),
    .mm2reg (mm2reg),
    .fwd    (fwda)
  );

  pipe_fwd_sel u_fwd_b (
    .src    (rt),
    .ern    (ern),
    .ewreg  (ewreg),
    .em2reg (em2reg),
    .mrn    (mrn),
    .mwreg  (mwreg),
    .mm2reg (mm2reg),
    .fwd    (fwdb)
  );

  // A load in EXE cannot be forwarded to ID in time; hold ID and bubble EXE.
  assign lu = ewreg && em2reg && (ern != R0) &&
              ((use_rs && (rs == ern)) || (use_rt && (rt == ern)));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    bus_err_d  = 1'b0;
    wpcir      = 1'b1;
    de_en      = 1'b1;
    de_bubble  = 1'b0;
    if_flush   = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          wpcir      = 1'b0;
          de_en      = 1'b0;
          state_d    = ST_MEMWAIT;
          wait_cnt_d = '0;
        end else if (lu) begin
          // The branch (if any) stays in ID and is re-resolved next cycle.
          wpcir     = 1'b0;
          de_bubble = 1'b1;
        end else if (br_taken) begin
          if_flush = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        wpcir = 1'b0;
        de_en = 1'b0;
        if (mem_ack) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ST_RUN;
          bus_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!wpcir && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      bus_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus_err   = bus_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, directed multi-cycle
// sequences and a randomized run against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int WAIT_MAX = 16;
  localparam int CNT_W    = 16;

  logic             clock;
  logic             resetn;
  logic [4:0]       rs, rt, ern, mrn;
  logic             use_rs, use_rt, br_taken;
  logic             ewreg, em2reg, mwreg, mm2reg, mem_req, mem_ack;
  logic [1:0]       fwda, fwdb;
  logic             wpcir, de_en, de_bubble, if_flush, bus_err;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .rs        (rs),
    .rt        (rt),
    .use_rs    (use_rs),
    .use_rt    (use_rt),
    .br_taken  (br_taken),
    .ern       (ern),
    .ewreg     (ewreg),
    .em2reg    (em2reg),
    .mrn       (mrn),
    .mwreg     (mwreg),
    .mm2reg    (mm2reg),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .fwda      (fwda),
    .fwdb      (fwdb),
    .wpcir     (wpcir),
    .de_en     (de_en),
    .de_bubble (de_bubble),
    .if_flush  (if_flush),
    .bus_err   (bus_err),
    .stall_cnt (stall_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int rs, rt, use_rs, use_rt, br;
    int ern, ewreg, em2reg;
    int mrn, mwreg, mm2reg;
    int req, ack;
  } in_t;

  typedef struct {
    string name;
    in_t   in;
    int    fa, fb, wp, de, bub, fl;
  } vec_t;

  typedef struct {
    int fa, fb, wp, de, bub, fl;
  } exp_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vq[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic in_t mk(input int a_rs, a_rt, a_urs, a_urt, a_br,
                             a_ern, a_ew, a_em, a_mrn, a_mw, a_mm,
                             a_req, a_ack);
    in_t v;
    v.rs = a_rs;   v.rt = a_rt;   v.use_rs = a_urs; v.use_rt = a_urt;
    v.br = a_br;   v.ern = a_ern; v.ewreg = a_ew;   v.em2reg = a_em;
    v.mrn = a_mrn; v.mwreg = a_mw; v.mm2reg = a_mm;
    v.req = a_req; v.ack = a_ack;
    return v;
  endfunction

  task automatic add_vec(input string name, input in_t in,
                         input int fa, fb, wp, de, bub, fl);
    vec_t e;
    e.name = name; e.in = in;
    e.fa = fa; e.fb = fb; e.wp = wp; e.de = de; e.bub = bub; e.fl = fl;
    vq.push_back(e);
  endtask

  task automatic apply(input in_t v);
    rs = 5'(v.rs);   rt = 5'(v.rt);
    use_rs = v.use_rs[0]; use_rt = v.use_rt[0]; br_taken = v.br[0];
    ern = 5'(v.ern); ewreg = v.ewreg[0]; em2reg = v.em2reg[0];
    mrn = 5'(v.mrn); mwreg = v.mwreg[0]; mm2reg = v.mm2reg[0];
    mem_req = v.req[0]; mem_ack = v.ack[0];
  endtask

  in_t idle_in;

  task automatic do_reset();
    apply(idle_in);
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_ctrl(input string tag, input int wp, de, bub, fl);
    check({tag, ".wpcir"},     int'(wpcir),     wp);
    check({tag, ".de_en"},     int'(de_en),     de);
    check({tag, ".de_bubble"}, int'(de_bubble), bub);
    check({tag, ".if_flush"},  int'(if_flush),  fl);
  endtask

  // Behavioural model: forwarding by priority of the freshest producer.
  function automatic int fwd_model(input int src, input in_t v);
    if (v.ewreg != 0 && v.em2reg == 0 && v.ern != 0 && v.ern == src) return 1;
    if (v.mwreg != 0 && v.mrn != 0 && v.mrn == src) return (v.mm2reg != 0) ? 3 : 2;
    return 0;
  endfunction

  function automatic exp_t ctrl_model(input in_t v, input bit waiting);
    exp_t e;
    bit   load_use;
    e.fa = fwd_model(v.rs, v);
    e.fb = fwd_model(v.rt, v);
    load_use = (v.ewreg != 0) && (v.em2reg != 0) && (v.ern != 0) &&
               ((v.use_rs != 0 && v.rs == v.ern) || (v.use_rt != 0 && v.rt == v.ern));
    e.wp = 1; e.de = 1; e.bub = 0; e.fl = 0;
    if (waiting || (v.req != 0 && v.ack == 0)) begin
      e.wp = 0; e.de = 0;
    end else if (load_use) begin
      e.wp = 0; e.bub = 1;
    end else begin
      e.fl = v.br;
    end
    return e;
  endfunction

  // Model state for the randomized phase.
  bit m_wait;
  int m_waited;
  int m_stall;
  int m_berr;

  initial begin
    in_t  v;
    exp_t e;
    int   thr;

    idle_in = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0);
    resetn  = 1'b1;
    apply(idle_in);
    #2;
    resetn = 1'b0;
    #1;
    check("reset.wpcir",     int'(wpcir),     1);
    check("reset.de_en",     int'(de_en),     1);
    check("reset.de_bubble", int'(de_bubble), 0);
    check("reset.if_flush",  int'(if_flush),  0);
    check("reset.fwda",      int'(fwda),      0);
    check("reset.fwdb",      int'(fwdb),      0);
    check("reset.bus_err",   int'(bus_err),   0);
    check("reset.stall_cnt", int'(stall_cnt), 0);

    // ---------------- vector table (RUN state, single cycle) ----------------
    add_vec("idle",        mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0),  0,0, 1,1,0,0);
    add_vec("exe_alu_rs",  mk(5,1,1,0,0, 5,1,0, 0,0,0, 0,0),  1,0, 1,1,0,0);
    add_vec("exe_r0",      mk(0,1,1,0,0, 0,1,0, 0,0,0, 0,0),  0,0, 1,1,0,0);
    add_vec("mem_alu_rt",  mk(1,7,0,1,0, 0,0,0, 7,1,0, 0,0),  0,2, 1,1,0,0);
    add_vec("mem_load_rs", mk(7,2,1,0,0, 0,0,0, 7,1,1, 0,0),  3,0, 1,1,0,0);
    add_vec("exe_beats_mem", mk(3,3,1,1,0, 3,1,0, 3,1,0, 0,0), 1,1, 1,1,0,0);
    add_vec("mem_r0",      mk(0,0,1,1,0, 0,0,0, 0,1,1, 0,0),  0,0, 1,1,0,0);
    add_vec("load_use_rt", mk(1,8,0,1,1, 8,1,1, 0,0,0, 0,0),  0,0, 0,1,1,0);
    add_vec("load_unused", mk(1,8,0,0,1, 8,1,1, 0,0,0, 0,0),  0,0, 1,1,0,1);
    add_vec("load_r0",     mk(0,0,1,1,0, 0,1,1, 0,0,0, 0,0),  0,0, 1,1,0,0);
    add_vec("branch",      mk(2,3,1,1,1, 4,1,0, 6,1,0, 0,0),  0,0, 1,1,0,1);
    add_vec("zero_wait",   mk(0,0,0,0,0, 0,0,0, 0,0,0, 1,1),  0,0, 1,1,0,0);
    add_vec("zw_load_use", mk(9,0,1,0,0, 9,1,1, 0,0,0, 1,1),  0,0, 0,1,1,0);

    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i].in);
      @(negedge clock);
      check({vq[i].name, ".fwda"}, int'(fwda), vq[i].fa);
      check({vq[i].name, ".fwdb"}, int'(fwdb), vq[i].fb);
      check_ctrl(vq[i].name, vq[i].wp, vq[i].de, vq[i].bub, vq[i].fl);
      next_cycle();
    end

    // ---------------- load-use then forward from MEM load ----------------
    do_reset();
    apply(mk(1,8,0,1,1, 8,1,1, 0,0,0, 0,0));
    @(negedge clock);
    check_ctrl("lu1", 0, 1, 1, 0);
    next_cycle();
    apply(mk(1,8,0,1,1, 0,0,0, 8,1,1, 0,0));
    @(negedge clock);
    check("lu2.fwdb", int'(fwdb), 3);
    check_ctrl("lu2", 1, 1, 0, 1);
    check("lu2.stall_cnt", int'(stall_cnt), 1);
    next_cycle();

    // ---------------- MEM wait: ack after three low cycles ----------------
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(mk(0,0,0,0,0, 0,0,0, 0,0,0, 1, (i == 3) ? 1 : 0));
      @(negedge clock);
      check("memwait.wpcir", int'(wpcir), 0);
      check("memwait.de_en", int'(de_en), 0);
      next_cycle();
    end
    apply(idle_in);
    @(negedge clock);
    check_ctrl("memwait_done", 1, 1, 0, 0);
    check("memwait_done.stall_cnt", int'(stall_cnt), 4);
    check("memwait_done.bus_err",   int'(bus_err),   0);
    next_cycle();

    // ---------------- timeout ----------------
    do_reset();
    apply(mk(0,0,0,0,0, 0,0,0, 0,0,0, 1,0));
    @(negedge clock);
    check("to_enter.wpcir", int'(wpcir), 0);
    next_cycle();
    apply(idle_in);
    for (int i = 0; i < WAIT_MAX; i++) begin
      @(negedge clock);
      check("to_wait.wpcir",   int'(wpcir),   0);
      check("to_wait.bus_err", int'(bus_err), 0);
      next_cycle();
    end
    @(negedge clock);
    check("to_done.bus_err",   int'(bus_err),   1);
    check("to_done.wpcir",     int'(wpcir),     1);
    check("to_done.stall_cnt", int'(stall_cnt), WAIT_MAX + 1);
    next_cycle();
    @(negedge clock);
    check("to_after.bus_err", int'(bus_err), 0);
    next_cycle();

    // ---------------- zero-wait access ----------------
    do_reset();
    apply(mk(0,0,0,0,0, 0,0,0, 0,0,0, 1,1));
    @(negedge clock);
    check("zw.wpcir", int'(wpcir), 1);
    check("zw.de_en", int'(de_en), 1);
    next_cycle();
    apply(idle_in);
    @(negedge clock);
    check("zw.stall_cnt", int'(stall_cnt), 0);
    check("zw_after.wpcir", int'(wpcir), 1);
    next_cycle();

    // ---------------- reset mid-MEMWAIT ----------------
    do_reset();
    apply(mk(0,0,0,0,0, 0,0,0, 0,0,0, 1,0));
    next_cycle();
    next_cycle();
    apply(idle_in);
    @(negedge clock);
    check("rst_mw_pre.wpcir", int'(wpcir), 0);
    resetn = 1'b0;
    #1;
    check("rst_mw.wpcir",     int'(wpcir),     1);
    check("rst_mw.stall_cnt", int'(stall_cnt), 0);
    #2;
    resetn = 1'b1;
    next_cycle();
    @(negedge clock);
    check("rst_mw_after.wpcir",     int'(wpcir),     1);
    check("rst_mw_after.de_en",     int'(de_en),     1);
    check("rst_mw_after.stall_cnt", int'(stall_cnt), 0);
    check("rst_mw_after.bus_err",   int'(bus_err),   0);
    next_cycle();

    // ---------------- randomized run against the model ----------------
    do_reset();
    m_wait = 0; m_waited = 0; m_stall = 0; m_berr = 0;
    for (int blk = 0; blk < 8; blk++) begin
      thr = (blk % 4) * 3;
      for (int c = 0; c < 250; c++) begin
        v = mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 3) == 0),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)),
               int'($urandom_range(0, 4) == 0),
               int'($urandom_range(0, 9) < thr));
        apply(v);
        @(negedge clock);
        e = ctrl_model(v, m_wait);
        check("rnd.fwda",      int'(fwda),      e.fa);
        check("rnd.fwdb",      int'(fwdb),      e.fb);
        check_ctrl("rnd", e.wp, e.de, e.bub, e.fl);
        check("rnd.bus_err",   int'(bus_err),   m_berr);
        check("rnd.stall_cnt", int'(stall_cnt), m_stall);
        @(posedge clock);
        m_berr = 0;
        if (e.wp == 0 && m_stall < (1 << CNT_W) - 1) m_stall++;
        if (!m_wait) begin
          if (v.req != 0 && v.ack == 0) begin
            m_wait   = 1;
            m_waited = 0;
          end
        end else if (v.ack != 0) begin
          m_wait = 0;
        end else if (m_waited == WAIT_MAX - 1) begin
          m_wait = 0;
          m_berr = 1;
        end else begin
          m_waited++;
        end
        #1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
